// File: rtl/score_scan_ctrl.sv
// Score display controller: shift-add-3 BCD conversion, source select, digit scan and blink.
// Optional macro DISP_LZB_EN blanks a zero tens digit (leading-zero suppression).
module score_scan_ctrl #(
  parameter int REFRESH_DIV = 4,
  parameter int BLINK_DIV   = 8,
  parameter int MAX_VALUE   = 99
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [7:0] score,
  input  logic [7:0] high_score,
  input  logic       game_over,
  input  logic       update,
  output logic       busy,
  output logic [3:0] digit,
  output logic [1:0] digit_sel,
  output logic       blank
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [7:0]    MAX_V    = 8'(MAX_VALUE);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

  state_t        state_q, state_d;
  logic          busy_q, busy_d;
  logic          pending_q, pending_d;
  logic [2:0]    iter_q, iter_d;
  logic [7:0]    bin_q, bin_d;
  logic [7:0]    bcd_q, bcd_d;
  logic [3:0]    ones_q, ones_d;
  logic [3:0]    tens_q, tens_d;
  logic          go_q, go_d;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic [3:0]    digit_q, digit_d;
  logic          blank_q, blank_d;

  logic        trigger;
  logic        wrap;
  logic        lz_blank;
  logic [7:0]  src;
  logic [7:0]  clamped;
  logic [7:0]  bcd_adj;
  logic [15:0] shifted;

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    iter_d      = iter_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    ones_d      = ones_q;
    tens_d      = tens_q;
    ref_cnt_d   = ref_cnt_q;
    sel_d       = sel_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;

    trigger = update | (game_over != go_q);
    go_d    = game_over;
    src     = game_over ? high_score : score;
    clamped = (src > MAX_V) ? MAX_V : src;
    bcd_adj[3:0] = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    bcd_adj[7:4] = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
    shifted = {bcd_adj, bin_q} << 1;

    case (state_q)
      IDLE: if (trigger) state_d = LOAD;
      LOAD: begin
        bin_d   = clamped;
        bcd_d   = 8'd0;
        iter_d  = 3'd0;
        state_d = SHIFT;
        if (trigger) pending_d = 1'b1;
      end
      SHIFT: begin
        bcd_d  = shifted[15:8];
        bin_d  = shifted[7:0];
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) state_d = COMMIT;
        if (trigger) pending_d = 1'b1;
      end
      COMMIT: begin
        ones_d    = bcd_q[3:0];
        tens_d    = bcd_q[7:4];
        pending_d = 1'b0;
        // A trigger landing in COMMIT is served straight away, like one seen in IDLE.
        state_d   = (pending_q || trigger) ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);

    wrap      = (ref_cnt_q == REF_LAST);
    ref_cnt_d = wrap ? '0 : ref_cnt_q + 1'b1;
    sel_d     = wrap ? {sel_q[0], sel_q[1]} : sel_q;

    if (game_over != go_q) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (!game_over) begin
      phase_d = 1'b1;
    end else if (wrap) begin
      if (blink_cnt_q == BLK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    // Outputs are computed from next-state values so select, digit and blank stay coherent.
    digit_d = sel_d[1] ? tens_d : ones_d;
`ifdef DISP_LZB_EN
    lz_blank = sel_d[1] && (tens_d == 4'd0);
`else
    lz_blank = 1'b0;
`endif
    blank_d = ~phase_d | lz_blank;
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      pending_q   <= 1'b0;
      iter_q      <= 3'd0;
      bin_q       <= 8'd0;
      bcd_q       <= 8'd0;
      ones_q      <= 4'd0;
      tens_q      <= 4'd0;
      go_q        <= 1'b0;
      ref_cnt_q   <= '0;
      sel_q       <= 2'b01;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      digit_q     <= 4'd0;
      blank_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      pending_q   <= pending_d;
      iter_q      <= iter_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      ones_q      <= ones_d;
      tens_q      <= tens_d;
      go_q        <= go_d;
      ref_cnt_q   <= ref_cnt_d;
      sel_q       <= sel_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      digit_q     <= digit_d;
      blank_q     <= blank_d;
    end
  end

  assign busy      = busy_q;
  assign digit     = digit_q;
  assign digit_sel = sel_q;
  assign blank     = blank_q;

endmodule

// File: tb/tb_score_scan_ctrl.sv
// Directed bench for score_scan_ctrl with REFRESH_DIV=4, BLINK_DIV=2, MAX_VALUE=99.
module tb_score_scan_ctrl;

  localparam int REFRESH_DIV = 4;
  localparam int BLINK_DIV   = 2;

  logic       clk = 1'b0;
  logic       nRst;
  logic [7:0] score;
  logic [7:0] high_score;
  logic       game_over;
  logic       update;
  logic       busy;
  logic [3:0] digit;
  logic [1:0] digit_sel;
  logic       blank;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  score_scan_ctrl #(.REFRESH_DIV(REFRESH_DIV), .BLINK_DIV(BLINK_DIV), .MAX_VALUE(99)) dut (
    .clk(clk), .nRst(nRst), .score(score), .high_score(high_score),
    .game_over(game_over), .update(update), .busy(busy), .digit(digit),
    .digit_sel(digit_sel), .blank(blank)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Checks the scanned digits against the next queued {tens, ones} over two full slot periods.
  task automatic check_display(input string tag);
    logic [7:0] e;
    logic seen_ones, seen_tens;
    e = exp_q.pop_front();
    seen_ones = 1'b0;
    seen_tens = 1'b0;
    for (int i = 0; i < 2 * REFRESH_DIV; i++) begin
      if (digit_sel == 2'b01) begin
        check_eq({tag, "_ones"}, digit, e[3:0]);
        seen_ones = 1'b1;
      end else begin
        check_eq({tag, "_sel"}, digit_sel, 2'b10);
        check_eq({tag, "_tens"}, digit, e[7:4]);
        seen_tens = 1'b1;
      end
      step();
    end
    check_eq({tag, "_both_slots"}, {seen_tens, seen_ones}, 2'b11);
  endtask

  // Pulses update in the current cycle and checks busy over the ten-cycle conversion.
  task automatic convert(input string tag, input logic [7:0] s, input logic [3:0] t, input logic [3:0] o);
    score = s;
    exp_q.push_back({t, o});
    update = 1'b1;
    step();
    update = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      check_eq({tag, "_busy_hi"}, busy, 1'b1);
      step();
    end
    check_eq({tag, "_busy_lo"}, busy, 1'b0);
    check_display(tag);
  endtask

  logic [7:0] vec_in [7];
  logic [7:0] vec_out[7];
  logic       bk[40];

  initial begin
    int t1;
    nRst = 1'b0; score = 8'd0; high_score = 8'd0; game_over = 1'b0; update = 1'b0;
    vec_in  = '{8'd37, 8'd200, 8'd99, 8'd100, 8'd0, 8'd9, 8'd255};
    vec_out = '{8'h37, 8'h99, 8'h99, 8'h99, 8'h00, 8'h09, 8'h99};
    step(); step(); step();
    nRst = 1'b1;

    // Idle scan straight out of reset
    for (int i = 0; i <= 8; i++) begin
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_digit", digit, 4'd0);
      check_eq("rst_sel", digit_sel, (i >= 4 && i < 8) ? 2'b10 : 2'b01);
`ifdef DISP_LZB_EN
      check_eq("rst_blank", blank, (i >= 4 && i < 8) ? 1'b1 : 1'b0);
`else
      check_eq("rst_blank", blank, 1'b0);
`endif
      step();
    end

    for (int v = 0; v < 7; v++)
      convert("vec", vec_in[v], vec_out[v][7:4], vec_out[v][3:0]);

    // Pending merge: extra updates at busy cycles 3 and 6, score changes before second LOAD
    score = 8'd12;
    update = 1'b1;
    step();
    update = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      check_eq("merge_busy", busy, 1'b1);
      if (c >= 11) check_eq("merge_mid", digit, (digit_sel == 2'b01) ? 4'd2 : 4'd1);
      update = (c == 3 || c == 6);
      if (c == 8) score = 8'd45;
      step();
    end
    update = 1'b0;
    check_eq("merge_busy_lo", busy, 1'b0);
    exp_q.push_back(8'h45);
    check_display("merge");
    check_eq("merge_single", busy, 1'b0);

    // game_over rise: auto conversion of high score, then blink
    score = 8'd0;
    high_score = 8'd50;
    game_over = 1'b1;
    step();
    for (int k = 0; k < 40; k++) begin
      bk[k] = blank;
      if (k < 10) check_eq("go_busy", busy, 1'b1);
      else check_eq("go_digit", digit, (digit_sel == 2'b01) ? 4'd0 : 4'd5);
      step();
    end
    check_eq("go_first_visible", bk[0], 1'b0);
    t1 = 0;
    for (int k = 39; k >= 1; k--) if (bk[k] && !bk[k-1]) t1 = k;
    for (int k = 1; k < 40; k++) if (t1 == 0 && bk[k]) t1 = k;
    check_eq("go_first_toggle_ok", (t1 >= 5 && t1 <= 8), 1'b1);
    if (t1 >= 5 && t1 <= 8) begin
      for (int m = 0; m < 24; m++)
        check_eq("go_blink", bk[t1 + m], ((m / 8) % 2 == 0) ? 1'b1 : 1'b0);
    end

    // game_over fall: reconvert score, blinking stops
    game_over = 1'b0;
    step();
    for (int k = 0; k < 20; k++) begin
      check_eq("gf_blank", blank, 1'b0);
      if (k < 10) check_eq("gf_busy", busy, 1'b1);
      else check_eq("gf_digit", digit, 4'd0);
      step();
    end

    // Reset during SHIFT cycle 4 aborts the conversion
    convert("pre_rst", 8'd63, 4'd6, 4'd3);
    score = 8'd81;
    update = 1'b1;
    step();
    update = 1'b0;
    for (int i = 0; i < 4; i++) step();
    nRst = 1'b0;
    step();
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_digit", digit, 4'd0);
    check_eq("mid_rst_sel", digit_sel, 2'b01);
    nRst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      check_eq("post_rst_busy", busy, 1'b0);
      check_eq("post_rst_digit", digit, 4'd0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
